// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty core fetch path.
//   DEF_ADDR_W / DEF_INSTR_W / DEF_FIFO_DEPTH / DEF_RESET_PC : default parameter values
//   fetch_state_e : fetch sequencer states
package bitty_pkg;

  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_INSTR_W    = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned DEF_RESET_PC   = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/bitty_fetch_fifo.sv
// Synchronous FIFO buffering fetched {instruction, pc} entries.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_push, i_data      : write request and entry
//   i_pop               : read request (ignored when empty)
//   i_clear             : drop all entries (wins over push/pop)
//   o_head              : oldest entry (registered storage)
//   o_count, o_full, o_empty : occupancy status
module bitty_fetch_fifo
  import bitty_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch for the bitty core: PC generation, synchronous memory reads,
// buffering and valid/ready delivery, with redirect flush.
//   i_clk, i_reset                : clock, synchronous active-high reset
//   o_mem_rd_en, o_mem_addr       : instruction memory read request
//   i_mem_rdata                   : read data, one cycle after o_mem_rd_en
//   o_instr_valid, i_instr_ready  : delivery handshake to the core
//   o_instr_data, o_instr_pc      : instruction word and its fetch address
//   i_redirect_valid, i_redirect_pc : fetch restart request from the core
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned INSTR_W    = DEF_INSTR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_mem_rd_en,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_rdata,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [INSTR_W-1:0] o_instr_data,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_epoch;
  logic                r_inflight;
  logic                r_inflight_epoch;
  logic [ADDR_W-1:0]   r_inflight_addr;

  logic [ENTRY_W-1:0]  w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_redirect;
  logic                w_fetching;
  logic [OCC_W-1:0]    w_occupancy;
  logic                w_issue;

  assign w_pop      = !w_empty && i_instr_ready;
  assign w_redirect = i_redirect_valid && (r_state != FETCH_IDLE);
  // Responses from an older epoch, or arriving in a redirect cycle, are stale.
  assign w_push     = r_inflight && (r_inflight_epoch == r_epoch) && !w_redirect;
  assign w_fetching = (r_state == FETCH_RUN) || (r_state == FETCH_FLUSH);

  // Slots that will be claimed after this edge, counting the response landing now.
  assign w_occupancy = OCC_W'(w_count) + OCC_W'(w_push) - OCC_W'(w_pop);
  assign w_issue     = w_fetching && !i_reset && !i_redirect_valid &&
                       (w_occupancy < OCC_W'(FIFO_DEPTH)) && (!w_full || w_pop);

  assign o_mem_rd_en   = w_issue;
  assign o_mem_addr    = w_issue ? r_pc : '0;
  assign o_instr_valid = !w_empty;
  assign o_instr_data  = w_head[ENTRY_W-1:ADDR_W];
  assign o_instr_pc    = w_head[ADDR_W-1:0];

  // Sequencer, PC, epoch and in-flight read tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= FETCH_IDLE;
      r_pc             <= ADDR_W'(RESET_PC);
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_inflight_addr  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr  <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
      if (w_redirect) begin
        r_pc    <= i_redirect_pc;
        r_epoch <= ~r_epoch;
      end else if (w_issue) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
      case (r_state)
        FETCH_IDLE:  r_state <= FETCH_RUN;
        FETCH_RUN:   if (i_redirect_valid) r_state <= FETCH_FLUSH;
        FETCH_FLUSH: if (!i_redirect_valid) r_state <= FETCH_RUN;
        default:     r_state <= FETCH_IDLE;
      endcase
    end
  end

  bitty_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({i_mem_rdata, r_inflight_addr}),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Scoreboard bench for bitty_fetch_unit: stimulus queues expected {pc, data}
// entries, a negedge monitor pops and compares on every accepted handshake.
module tb_bitty_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;

  logic [15:0] mem [256];
  logic [23:0] exp_q [$];
  int          n_total = 0;
  int          n_pass  = 0;

  logic        stall_pend = 1'b0;
  logic [15:0] stall_data;
  logic [7:0]  stall_pc;

  always #5 clk = ~clk;

  bitty_fetch_unit dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_mem_rd_en      (mem_rd_en),
    .o_mem_addr       (mem_addr),
    .i_mem_rdata      (mem_rdata),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr_data     (instr_data),
    .o_instr_pc       (instr_pc),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input string got, input string want);
    n_total++;
    $display("FAIL %s: got %s, expected %s", name, got, want);
  endtask

  task automatic push_exp(input logic [7:0] pc);
    logic [15:0] d;
    d = 16'hA000 + {8'h00, pc};
    exp_q.push_back({pc, d});
  endtask

  // Monitor: in-order scoreboard plus stability of a stalled head.
  always @(negedge clk) begin
    logic [23:0] e;
    if (stall_pend) begin
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_data", 32'(instr_data), 32'(stall_data));
      check("stall_pc", 32'(instr_pc), 32'(stall_pc));
    end
    stall_pend = 1'b0;
    if (!reset && !redirect_valid && instr_valid && !instr_ready) begin
      stall_pend = 1'b1;
      stall_data = instr_data;
      stall_pc   = instr_pc;
    end
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        fail_event("unexpected_instr", $sformatf("pc 0x%0h", instr_pc), "no instruction");
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", 32'(instr_pc), 32'(e[23:16]));
        check("instr_data", 32'(instr_data), 32'(e[15:0]));
      end
    end
  end

  // Two reset edges, check reset outputs, release; returns in cycle 0 (IDLE).
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data", 32'(instr_data), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0)
      fail_event("drain_timeout", $sformatf("%0d pending", exp_q.size()), "0 pending");
  endtask

  task automatic redirect_to(input logic [7:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [0:3] exp_rd;
    logic [7:0] exp_addr [4];
    logic [0:3] exp_vld;
    int         reads;
    bit         found;

    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    exp_rd   = 4'b0111;
    exp_addr = '{8'h00, 8'h00, 8'h01, 8'h02};
    exp_vld  = 4'b0001;

    // Startup timing: reads from cycle 1, first instruction in cycle 3.
    instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(8'(i));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("start_rd_c%0d", c), 32'(mem_rd_en), 32'(exp_rd[c]));
      check($sformatf("start_addr_c%0d", c), 32'(mem_addr), 32'(exp_addr[c]));
      check($sformatf("start_valid_c%0d", c), 32'(instr_valid), 32'(exp_vld[c]));
    end
    wait_drain(40);
    instr_ready = 1'b0;

    // Back-pressure: only FIFO_DEPTH reads while stalled, then ordered release.
    do_reset();
    reads = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_rd_en) reads++;
    end
    check("stall_read_count", 32'(reads), 32'd2);
    check("stall_rd_en_low", 32'(mem_rd_en), 32'd0);
    push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_drain(40);
    instr_ready = 1'b0;

    // Redirect to 0x40 while the read of 0x05 is in flight.
    do_reset();
    for (int i = 0; i < 5; i++) push_exp(8'(i));
    for (int i = 0; i < 4; i++) push_exp(8'h40 + 8'(i));
    instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 8'h05) found = 1'b1;
    end
    if (!found) fail_event("read5_timeout", "no read of 0x05", "read of 0x05");
    @(posedge clk); #1;
    redirect_to(8'h40);
    wait_drain(40);
    instr_ready = 1'b0;

    // Back-to-back redirects while stalled: the last target wins.
    repeat (4) @(posedge clk); #1;
    redirect_to(8'h80);
    #0;
    @(negedge clk);
    @(posedge clk); #1;
    push_exp(8'h90); push_exp(8'h91); push_exp(8'h92);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    @(posedge clk); #1;
    redirect_pc    = 8'h90;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    wait_drain(40);
    instr_ready = 1'b0;

    // PC wrap from 0xFE.
    repeat (3) @(posedge clk); #1;
    push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00); push_exp(8'h01);
    redirect_to(8'hFE);
    instr_ready = 1'b1;
    wait_drain(40);
    instr_ready = 1'b0;

    // Random back-pressure: in order, stable while stalled.
    do_reset();
    for (int i = 0; i < 1100; i++) push_exp(8'(i));
    for (int c = 0; c < 1000; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    instr_ready = 1'b0;
    check("random_progress", 32'(exp_q.size() < 1000), 32'd1);

    // Reset mid-stream with the read of 0x03 in flight.
    do_reset();
    for (int i = 0; i < 10; i++) push_exp(8'(i));
    instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 8'h03) found = 1'b1;
    end
    if (!found) fail_event("read3_timeout", "no read of 0x03", "read of 0x03");
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(8'(i));
    wait_drain(40);
    instr_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
